// File: rtl/multi_channel_debouncer.sv
// -----------------------------------------------------------------------------
// multi_channel_debouncer
//
// Purpose:
//   N-channel push-button conditioner for the front panel. Each channel has
//   its own 2-FF synchroniser, stability counter and 4-state FSM
//   (LOW, WAIT_HI, HIGH, WAIT_LO). One instance serves every button.
//
// Ports:
//   clk        in   1     system clock (single domain)
//   reset      in   1     synchronous, active-high reset
//   btn_in     in   N_CH  raw asynchronous button inputs, active-high
//   db_level   out  N_CH  debounced level per channel (registered)
//   db_press   out  N_CH  1-cycle pulse when db_level first reads 1
//                         (and on every auto-repeat when that build option is on)
//   db_release out  N_CH  1-cycle pulse when db_level first reads 0
//
// Build option:
//   DEBOUNCE_AUTOREPEAT_EN  when defined, a held button (state HIGH) produces
//                           extra db_press pulses: the first REPEAT_DELAY cycles
//                           after acceptance, then every REPEAT_PERIOD cycles.
//                           When undefined no repeat logic exists and exactly one
//                           db_press is produced per accepted press.
//
// Latency: a clean step on btn_in changes db_level STABLE_CNT+3 rising edges
// after the first edge that samples it (2 sync + FSM entry + STABLE_CNT).
// -----------------------------------------------------------------------------
module multi_channel_debouncer #(
    parameter int N_CH          = 3,
    parameter int STABLE_CNT    = 500000,
    parameter int CNT_W         = 20,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] db_level,
    output logic [N_CH-1:0] db_press,
    output logic [N_CH-1:0] db_release
);

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        WAIT_HI = 2'd1,
        HIGH    = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    // Configuration guard: the count must be able to reach STABLE_CNT-1, and
    // the repeat timings are kept legal in both builds so the option can be
    // toggled without touching the instantiation.
    if (STABLE_CNT < 2 || (STABLE_CNT - 1) >= (2 ** CNT_W)) begin : g_bad_stable_cfg
        $error("multi_channel_debouncer: STABLE_CNT must be >=2 and STABLE_CNT-1 must fit in CNT_W");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat_cfg
        $error("multi_channel_debouncer: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [N_CH-1:0]  sync_p0;
    logic [N_CH-1:0]  sync_p1;

    state_t           state_q [N_CH];
    state_t           state_d [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];

    logic [N_CH-1:0]  level_d;
    logic [N_CH-1:0]  press_d;
    logic [N_CH-1:0]  release_d;
    logic [N_CH-1:0]  rpt_fire;

    // ---- stage p0/p1: two-flop synchroniser, sync_p1 is the sampled level ----
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_in;
            sync_p1 <= sync_p0;
        end
    end

    // ---- FSM next state, counter and output decode per channel ----
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                LOW: begin
                    if (sync_p1[i]) begin
                        state_d[i] = WAIT_HI;
                        cnt_d[i]   = '0;
                    end
                end
                WAIT_HI: begin
                    if (!sync_p1[i]) begin
                        // glitch rejected: back to LOW without a pulse
                        state_d[i] = LOW;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = HIGH;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (!sync_p1[i]) begin
                        state_d[i] = WAIT_LO;
                        cnt_d[i]   = '0;
                    end
                end
                WAIT_LO: begin
                    if (sync_p1[i]) begin
                        state_d[i] = HIGH;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = LOW;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = LOW;
                    cnt_d[i]   = '0;
                end
            endcase

            // Outputs are decoded from the next state so they register on the
            // same edge as the state change; a WAIT_LO->HIGH return keeps the
            // level at 1 and produces no press.
            level_d[i]   = (state_d[i] == HIGH) || (state_d[i] == WAIT_LO);
            press_d[i]   = ((state_q[i] == WAIT_HI) && (state_d[i] == HIGH)) || rpt_fire[i];
            release_d[i] = (state_q[i] == WAIT_LO) && (state_d[i] == LOW);
        end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_V  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_PERIOD_V = RPT_W'(REPEAT_PERIOD);

    logic [RPT_W-1:0] rpt_q [N_CH];
    logic [RPT_W-1:0] rpt_d [N_CH];
    // 0: waiting for the first repeat (DELAY), 1: periodic repeats (PERIOD)
    logic [N_CH-1:0]  rpt_phase_q;
    logic [N_CH-1:0]  rpt_phase_d;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            rpt_d[i]       = rpt_q[i];
            rpt_phase_d[i] = rpt_phase_q[i];
            rpt_fire[i]    = 1'b0;
            if ((state_q[i] != HIGH) && (state_d[i] == HIGH)) begin
                // every (re)entry to HIGH restarts the repeat schedule
                rpt_d[i]       = '0;
                rpt_phase_d[i] = 1'b0;
            end else if ((state_q[i] == HIGH) && (state_d[i] == HIGH)) begin
                if ((rpt_q[i] + RPT_W'(1)) == (rpt_phase_q[i] ? RPT_PERIOD_V : RPT_DELAY_V)) begin
                    rpt_fire[i]    = 1'b1;
                    rpt_d[i]       = '0;
                    rpt_phase_d[i] = 1'b1;
                end else begin
                    rpt_d[i] = rpt_q[i] + RPT_W'(1);
                end
            end
            // WAIT_LO (and LOW/WAIT_HI) leave the repeat counter frozen
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                rpt_q[i] <= '0;
            end
            rpt_phase_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                rpt_q[i] <= rpt_d[i];
            end
            rpt_phase_q <= rpt_phase_d;
        end
    end
`else
    assign rpt_fire = '0;
`endif

    // ---- state/counter registers and registered outputs ----
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= LOW;
                cnt_q[i]   <= '0;
            end
            db_level   <= '0;
            db_press   <= '0;
            db_release <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            db_level   <= level_d;
            db_press   <= press_d;
            db_release <= release_d;
        end
    end

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// -----------------------------------------------------------------------------
// tb_multi_channel_debouncer
//
// Table of per-cycle vectors {reset, btn_in, expected level/press/release}.
// Each vector's expectation is queued when it is driven and compared one edge
// later. Expected timing: a step first sampled at vector k shows on db_level
// at vector k+6 (STABLE_CNT=4 -> 7 edges including the sampling edge).
// -----------------------------------------------------------------------------
module tb_multi_channel_debouncer;

    localparam int N_CH          = 3;
    localparam int STABLE_CNT    = 4;
    localparam int CNT_W         = 3;
    localparam int REPEAT_DELAY  = 20;
    localparam int REPEAT_PERIOD = 8;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam bit AUTORPT = 1'b1;
`else
    localparam bit AUTORPT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] db_level;
    logic [N_CH-1:0] db_press;
    logic [N_CH-1:0] db_release;

    always #5 clk = ~clk;

    multi_channel_debouncer #(
        .N_CH          (N_CH),
        .STABLE_CNT    (STABLE_CNT),
        .CNT_W         (CNT_W),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .db_level   (db_level),
        .db_press   (db_press),
        .db_release (db_release)
    );

    typedef struct {
        logic       rst;
        logic [2:0] btn;
        logic [2:0] lvl;
        logic [2:0] press;
        logic [2:0] rel;
    } vec_t;

    typedef struct {
        logic [2:0] lvl;
        logic [2:0] press;
        logic [2:0] rel;
        int         idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input int n, input logic r, input logic [2:0] b,
                       input logic [2:0] l, input logic [2:0] p, input logic [2:0] rl);
        repeat (n) vecs.push_back(vec_t'{r, b, l, p, rl});
    endtask

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    task automatic check_int(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    initial begin
        exp_t       e;
        logic [2:0] pmask;

        reset  = 1'b1;
        btn_in = '0;

        // 1: reset held with all buttons high, then first cycles after release
        add(3, 1'b1, 3'b111, 3'b000, 3'b000, 3'b000);
        add(3, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
        // 2: clean press on channel 0
        add(6, 1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
        add(1, 1'b0, 3'b001, 3'b001, 3'b001, 3'b000);
        add(3, 1'b0, 3'b001, 3'b001, 3'b000, 3'b000);
        // 3: channel 1 bounces 1,0,1,1,0 then settles at 1
        add(1, 1'b0, 3'b011, 3'b001, 3'b000, 3'b000);
        add(1, 1'b0, 3'b001, 3'b001, 3'b000, 3'b000);
        add(2, 1'b0, 3'b011, 3'b001, 3'b000, 3'b000);
        add(1, 1'b0, 3'b001, 3'b001, 3'b000, 3'b000);
        add(6, 1'b0, 3'b011, 3'b001, 3'b000, 3'b000);
        add(1, 1'b0, 3'b011, 3'b011, 3'b010, 3'b000);
        add(3, 1'b0, 3'b011, 3'b011, 3'b000, 3'b000);
        // 4: channel 2 press, 3-cycle low glitch (rejected), then real release
        add(6, 1'b0, 3'b111, 3'b011, 3'b000, 3'b000);
        add(1, 1'b0, 3'b111, 3'b111, 3'b100, 3'b000);
        add(3, 1'b0, 3'b111, 3'b111, 3'b000, 3'b000);
        add(3, 1'b0, 3'b011, 3'b111, 3'b000, 3'b000);
        add(4, 1'b0, 3'b111, 3'b111, 3'b000, 3'b000);
        add(6, 1'b0, 3'b011, 3'b111, 3'b000, 3'b000);
        add(1, 1'b0, 3'b011, 3'b011, 3'b000, 3'b100);
        add(3, 1'b0, 3'b011, 3'b011, 3'b000, 3'b000);
        // 5: release remaining channels together, then all press together and release
        add(6, 1'b0, 3'b000, 3'b011, 3'b000, 3'b000);
        add(1, 1'b0, 3'b000, 3'b000, 3'b000, 3'b011);
        add(3, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
        add(6, 1'b0, 3'b111, 3'b000, 3'b000, 3'b000);
        add(1, 1'b0, 3'b111, 3'b111, 3'b111, 3'b000);
        add(2, 1'b0, 3'b111, 3'b111, 3'b000, 3'b000);
        add(6, 1'b0, 3'b000, 3'b111, 3'b000, 3'b000);
        add(1, 1'b0, 3'b000, 3'b000, 3'b000, 3'b111);
        add(2, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
        // 6: reset during WAIT_HI abandons the count; full re-count afterwards
        add(3, 1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
        add(2, 1'b1, 3'b001, 3'b000, 3'b000, 3'b000);
        add(6, 1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
        add(1, 1'b0, 3'b001, 3'b001, 3'b001, 3'b000);
        add(2, 1'b0, 3'b001, 3'b001, 3'b000, 3'b000);
        // reset while HIGH clears the level immediately
        add(1, 1'b1, 3'b001, 3'b000, 3'b000, 3'b000);

        for (int k = 0; k < vecs.size(); k++) begin
            reset  = vecs[k].rst;
            btn_in = vecs[k].btn;
            sb.push_back(exp_t'{vecs[k].lvl, vecs[k].press, vecs[k].rel, k});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            // with auto-repeat built in, long holds add extra presses; only the
            // expected acceptance pulses are then checked on db_press
            pmask = AUTORPT ? e.press : 3'b111;
            check3($sformatf("v%0d db_level", e.idx),   db_level,          e.lvl);
            check3($sformatf("v%0d db_press", e.idx),   db_press & pmask,  e.press);
            check3($sformatf("v%0d db_release", e.idx), db_release,        e.rel);
            check3($sformatf("v%0d press_and_release", e.idx), db_press & db_release, 3'b000);
        end

`ifdef DEBOUNCE_AUTOREPEAT_EN
        begin
            int rq[$];
            int expc;
            reset  = 1'b0;
            btn_in = 3'b000;
            repeat (10) @(posedge clk);
            #1;
            // acceptance 6 edges after the step, then +20, +28, +36, ...
            rq = '{6, 26, 34, 42, 50, 58};
            btn_in = 3'b001;
            for (int c = 0; c < 62; c++) begin
                @(posedge clk);
                #1;
                if (db_press[0]) begin
                    if (rq.size() == 0) begin
                        check_int("autorepeat extra pulse cycle", c, -1);
                    end else begin
                        expc = rq.pop_front();
                        check_int("autorepeat pulse cycle", c, expc);
                    end
                end
            end
            check_int("autorepeat missing pulses", rq.size(), 0);
        end
`endif

        check_int("scoreboard drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
